// File: rtl/iob_reg_bank_pkg.sv
// iob_reg_bank_pkg
// Shared definitions for the IOb register bank: FSM state encoding, the
// byte-strobe width macro and the word-address range check.
// No ports (package).

`ifndef IOB_REG_BANK_PKG_DONE
`define IOB_REG_BANK_PKG_DONE
// Number of byte strobes for a data word of width dw.
`define IOB_REG_BANK_STRB_W(dw) ((dw) / 8)
`endif

package iob_reg_bank_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_RESP = 1'b1
    } state_t;

    // A word address is valid only below the register count. This also
    // rejects the unused codes when NREGS is not a power of two.
    function automatic logic addr_in_range(input int unsigned addr,
                                           input int unsigned nregs);
        return addr < nregs;
    endfunction

endpackage

// File: rtl/iob_reg_bank_if.sv
// iob_reg_bank_if
// IOb native bus between a CPU-side requester (master) and the register bank
// (slave).
//   iob_valid  master->slave  request valid
//   iob_addr   master->slave  word address, MSB set = out of range
//   iob_wdata  master->slave  write data
//   iob_wstrb  master->slave  byte strobes, all-zero = read
//   iob_ready  slave->master  request can be accepted this cycle
//   iob_rvalid slave->master  iob_rdata valid (one-cycle pulse)
//   iob_rdata  slave->master  read data
//
// Handshake: a request transfers on a rising edge where iob_valid and
// iob_ready are both 1. iob_ready never depends on iob_valid. A read
// response is signalled by iob_rvalid high for exactly one cycle and cannot
// be back-pressured; iob_rdata keeps its value until the next response.

interface iob_reg_bank_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
);
    logic                iob_valid;
    logic [ADDR_W:0]     iob_addr;
    logic [DATA_W-1:0]   iob_wdata;
    logic [DATA_W/8-1:0] iob_wstrb;
    logic                iob_ready;
    logic                iob_rvalid;
    logic [DATA_W-1:0]   iob_rdata;

    modport master (
        output iob_valid, iob_addr, iob_wdata, iob_wstrb,
        input  iob_ready, iob_rvalid, iob_rdata
    );

    modport slave (
        input  iob_valid, iob_addr, iob_wdata, iob_wstrb,
        output iob_ready, iob_rvalid, iob_rdata
    );
endinterface

// File: rtl/iob_reg_bank_word.sv
// iob_reg_bank_word
// One DATA_W-bit register of the bank.
//   clk        clock
//   arst_n     asynchronous active-low reset to RST_VAL
//   rst        synchronous clear to RST_VAL
//   be_i       per-byte write enable from the bus
//   wdata_i    bus write data
//   hw_en_i    hardware write enable   (IOB_REG_BANK_HW_WR_EN only)
//   hw_data_i  hardware write data     (IOB_REG_BANK_HW_WR_EN only)
//   q_o        register contents
// Macro: IOB_REG_BANK_HW_WR_EN adds the full-word hardware write port.

module iob_reg_bank_word #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                rst,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [DATA_W-1:0]   wdata_i,
`ifdef IOB_REG_BANK_HW_WR_EN
    input  logic                hw_en_i,
    input  logic [DATA_W-1:0]   hw_data_i,
`endif
    output logic [DATA_W-1:0]   q_o
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            q_o <= RST_VAL;
        end else if (rst) begin
            q_o <= RST_VAL;
`ifdef IOB_REG_BANK_HW_WR_EN
        end else if (hw_en_i) begin
            // Hardware owns the word this edge; any bus bytes are dropped.
            q_o <= hw_data_i;
`endif
        end else begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (be_i[b]) q_o[b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/iob_reg_bank.sv
// iob_reg_bank
// Bus-accessible bank of NREGS control/status registers, IOb responder side.
// Writes complete in the accepting cycle; reads answer one cycle later.
//   clk           clock
//   arst_n        asynchronous active-low reset
//   rst           synchronous clear, same effect as arst_n
//   iob           IOb bus, slave modport
//   regs_o        all registers, reg k at [k*DATA_W +: DATA_W]
//   addr_err_o    sticky out-of-range access flag
//   state_o       FSM state (debug)
//   hw_wr_en_i    per-register hardware write enable (IOB_REG_BANK_HW_WR_EN)
//   hw_wr_data_i  hardware write data               (IOB_REG_BANK_HW_WR_EN)
// Macro: IOB_REG_BANK_HW_WR_EN enables the hardware write port.

module iob_reg_bank
    import iob_reg_bank_pkg::*;
#(
    parameter int                NREGS   = 8,
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    rst,
    iob_reg_bank_if.slave           iob,
    output logic [NREGS*DATA_W-1:0] regs_o,
    output logic                    addr_err_o,
    output state_t                  state_o
`ifdef IOB_REG_BANK_HW_WR_EN
    ,
    input  logic [NREGS-1:0]        hw_wr_en_i,
    input  logic [NREGS*DATA_W-1:0] hw_wr_data_i
`endif
);

    localparam int ADDR_W = $clog2(NREGS);
    localparam int STRB_W = `IOB_REG_BANK_STRB_W(DATA_W);

    state_t              state_q, state_d;
    logic                accept, is_read, in_range;
    logic [ADDR_W-1:0]   addr_idx;
    logic [DATA_W-1:0]   word_q [NREGS];
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   rdata_q;
    logic                addr_err_q;

    assign iob.iob_ready  = (state_q == IDLE);
    assign iob.iob_rvalid = (state_q == RD_RESP);
    assign iob.iob_rdata  = rdata_q;
    assign addr_err_o     = addr_err_q;
    assign state_o        = state_q;

    assign accept   = iob.iob_valid & iob.iob_ready;
    assign is_read  = (iob.iob_wstrb == '0);
    assign in_range = addr_in_range(32'(iob.iob_addr), NREGS);
    assign addr_idx = iob.iob_addr[ADDR_W-1:0];

    for (genvar k = 0; k < NREGS; k++) begin : g_word
        logic [STRB_W-1:0] be;
        assign be = (accept && !is_read && in_range && addr_idx == ADDR_W'(k))
                    ? iob.iob_wstrb : '0;

        iob_reg_bank_word #(
            .DATA_W  (DATA_W),
            .RST_VAL (RST_VAL)
        ) u_word (
            .clk       (clk),
            .arst_n    (arst_n),
            .rst       (rst),
            .be_i      (be),
            .wdata_i   (iob.iob_wdata),
`ifdef IOB_REG_BANK_HW_WR_EN
            .hw_en_i   (hw_wr_en_i[k]),
            .hw_data_i (hw_wr_data_i[k*DATA_W +: DATA_W]),
`endif
            .q_o       (word_q[k])
        );

        assign regs_o[k*DATA_W +: DATA_W] = word_q[k];
    end

    // Out-of-range reads still answer, with zero data.
    always_comb begin
        rd_word = '0;
        if (in_range) rd_word = word_q[addr_idx];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && is_read) state_d = RD_RESP;
            RD_RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
        end else if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rdata_q    <= '0;
            addr_err_q <= 1'b0;
        end else if (rst) begin
            rdata_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            if (accept && is_read) rdata_q <= rd_word;
            if (accept && !in_range) addr_err_q <= 1'b1;
        end
    end

endmodule
